// File: rtl/divider_pkg.sv
// Shared CPU package: ALU operation types plus the divider state encoding and
// datapath width constants used by divider and div_step.
package divider_pkg;

   typedef enum logic [2:0] {
      ALU_ADD,
      ALU_ADC,
      ALU_SUB,
      ALU_SBB,
      ALU_AND,
      ALU_OR,
      ALU_XOR,
      ALU_CMP
   } alu_op_t;

   typedef enum logic [1:0] {
      DIV_IDLE,
      DIV_INIT,
      DIV_WORKING,
      DIV_FIXUP
   } div_state_t;

   localparam int DIV_W      = 16;
   localparam int BYTE_W     = 8;
   localparam int WORD_STEPS = 16;
   localparam int BYTE_STEPS = 8;
   localparam int CNT_W      = 4;

endpackage

// File: rtl/div_step.sv
// One restoring-division step: shift the next dividend bit into the partial
// remainder, subtract the divisor if it fits, and emit the quotient bit.
module div_step
   import divider_pkg::*;
(
   input  logic [DIV_W-1:0] rem,
   input  logic             bit_in,
   input  logic [DIV_W-1:0] divisor,
   output logic [DIV_W-1:0] rem_next,
   output logic             q_bit
);

   logic [DIV_W:0] shifted;
   logic [DIV_W:0] diff;

   assign shifted = {rem, bit_in};
   assign diff    = shifted - {1'b0, divisor};

   // rem < divisor always holds, so shifted < 2*divisor and the top bit of
   // diff is purely the borrow.
   assign q_bit    = ~diff[DIV_W];
   assign rem_next = q_bit ? diff[DIV_W-1:0] : shifted[DIV_W-1:0];

endmodule

// File: rtl/divider.sv
// 8086-style DIV/IDIV sequencer: byte or word restoring division, one quotient
// bit per cycle. Signed (IDIV) support is built only when DIVIDER_SIGNED_EN is defined.
module divider
   import divider_pkg::*;
(
   input  logic             clk,
   input  logic             reset_n,
   input  logic             start,
   input  logic             is_8_bit,
   input  logic             is_signed,
   input  logic [31:0]      dividend,
   input  logic [DIV_W-1:0] divisor,
   output logic [DIV_W-1:0] quotient,
   output logic [DIV_W-1:0] remainder,
   output logic             busy,
   output logic             complete,
   output logic             error
);

   div_state_t       state, state_next;
   logic [31:0]      dvd_q;
   logic [DIV_W-1:0] dvs_q, rem_q, low_q, quot_q, rmd_q;
   logic             byte_q;
   logic [CNT_W-1:0] cnt_q;
   logic             err_q;
   logic [31:0]      mag_dvd;
   logic [DIV_W-1:0] mag_dvs;
   logic             init_err;
   logic [DIV_W-1:0] step_rem;
   logic             step_q;
   logic [DIV_W-1:0] fix_q, fix_r;
   logic             fix_ovf;

`ifdef DIVIDER_SIGNED_EN
   logic             signed_q, neg_q_q, neg_r_q;
   logic             sd, sv;
   logic [31:0]      neg_dvd;
   logic [DIV_W-1:0] neg_dvs;

   assign neg_dvd = -dvd_q;
   assign neg_dvs = -dvs_q;
`else
   logic unused_signed;
   assign unused_signed = is_signed;
`endif

   div_step u_step (
      .rem      (rem_q),
      .bit_in   (low_q[DIV_W-1]),
      .divisor  (dvs_q),
      .rem_next (step_rem),
      .q_bit    (step_q)
   );

   // NOTE: every signal driven here gets a default first, so no path can infer a latch.
   always_comb begin
      mag_dvd = byte_q ? {16'h0, dvd_q[15:0]} : dvd_q;
      mag_dvs = byte_q ? {8'h0, dvs_q[BYTE_W-1:0]} : dvs_q;
`ifdef DIVIDER_SIGNED_EN
      sd = 1'b0;
      sv = 1'b0;
      if (signed_q) begin
         sd = byte_q ? dvd_q[15] : dvd_q[31];
         sv = byte_q ? dvs_q[BYTE_W-1] : dvs_q[DIV_W-1];
      end
      if (sd) mag_dvd = byte_q ? {16'h0, neg_dvd[15:0]} : neg_dvd;
      if (sv) mag_dvs = byte_q ? {8'h0, neg_dvs[BYTE_W-1:0]} : neg_dvs;
`endif
      // High half >= divisor covers both divide-by-zero and an unsigned quotient overflow.
      init_err = (mag_dvs == '0) ||
                 (byte_q ? (mag_dvd[15:8] >= mag_dvs[BYTE_W-1:0]) : (mag_dvd[31:16] >= mag_dvs));
   end

   always_comb begin
      fix_q   = low_q;
      fix_r   = rem_q;
      fix_ovf = 1'b0;
`ifdef DIVIDER_SIGNED_EN
      // Magnitude must fit n-1 bits; like the 8086, -2^(n-1) also traps.
      if (signed_q) fix_ovf = byte_q ? low_q[BYTE_W-1] : low_q[DIV_W-1];
      if (neg_q_q)  fix_q   = -low_q;
      if (neg_r_q)  fix_r   = -rem_q;
`endif
      if (byte_q) begin
         fix_q[DIV_W-1:BYTE_W] = '0;
         fix_r[DIV_W-1:BYTE_W] = '0;
      end
   end

   always_comb begin
      state_next = state;
      case (state)
         DIV_IDLE:    if (start) state_next = DIV_INIT;
         DIV_INIT:    state_next = init_err ? DIV_IDLE : DIV_WORKING;
         DIV_WORKING: if (cnt_q == '0) state_next = DIV_FIXUP;
         DIV_FIXUP:   state_next = DIV_IDLE;
         default:     state_next = DIV_IDLE;
      endcase
   end

   assign busy      = (state == DIV_INIT) || (state == DIV_WORKING);
   assign complete  = (state == DIV_FIXUP) && !fix_ovf;
   assign error     = err_q || ((state == DIV_FIXUP) && fix_ovf);
   assign quotient  = complete ? fix_q : quot_q;
   assign remainder = complete ? fix_r : rmd_q;

   // NOTE: sequential state uses <= so every flop updates from pre-edge values.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state  <= DIV_IDLE;
         err_q  <= 1'b0;
         quot_q <= '0;
         rmd_q  <= '0;
      end else begin
         state <= state_next;
         err_q <= (state == DIV_INIT) && init_err;
         if (complete) begin
            quot_q <= fix_q;
            rmd_q  <= fix_r;
         end
      end
   end

   // NOTE: operand and working registers are only read in states that loaded them first, so they carry no reset.
   always_ff @(posedge clk) begin
      case (state)
         DIV_IDLE: begin
            if (start) begin
               dvd_q  <= dividend;
               dvs_q  <= divisor;
               byte_q <= is_8_bit;
`ifdef DIVIDER_SIGNED_EN
               signed_q <= is_signed;
`endif
            end
         end
         DIV_INIT: begin
            dvs_q <= mag_dvs;
            rem_q <= byte_q ? {8'h0, mag_dvd[15:8]} : mag_dvd[31:16];
            low_q <= byte_q ? {mag_dvd[7:0], 8'h0} : mag_dvd[15:0];
            cnt_q <= byte_q ? CNT_W'(BYTE_STEPS - 1) : CNT_W'(WORD_STEPS - 1);
`ifdef DIVIDER_SIGNED_EN
            neg_q_q <= sd ^ sv;
            neg_r_q <= sd;
`endif
         end
         DIV_WORKING: begin
            rem_q <= step_rem;
            low_q <= {low_q[DIV_W-2:0], step_q};
            cnt_q <= cnt_q - 1'b1;
         end
         default: ;
      endcase
   end

endmodule

// File: tb/tb_divider.sv
// Scoreboard bench for divider: directed vectors push expected pulses (kind,
// cycle, results); a negedge monitor pops and compares each complete/error pulse.
module tb_divider;

   logic        clk = 1'b0;
   logic        reset_n = 1'b0;
   logic        start = 1'b0;
   logic        is_8_bit = 1'b0;
   logic        is_signed = 1'b0;
   logic [31:0] dividend = '0;
   logic [15:0] divisor = '0;
   logic [15:0] quotient, remainder;
   logic        busy, complete, error;

   divider dut (
      .clk       (clk),
      .reset_n   (reset_n),
      .start     (start),
      .is_8_bit  (is_8_bit),
      .is_signed (is_signed),
      .dividend  (dividend),
      .divisor   (divisor),
      .quotient  (quotient),
      .remainder (remainder),
      .busy      (busy),
      .complete  (complete),
      .error     (error)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic        err;
      logic [15:0] q;
      logic [15:0] r;
      int          cyc;
   } exp_t;

   exp_t        sb[$];
   exp_t        mon_e;
   int          cyc = 0;
   int          checks = 0;
   int          errors = 0;
   logic [15:0] prev_q = '0;
   logic [15:0] prev_r = '0;

   always @(posedge clk) cyc = cyc + 1;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks = checks + 1;
      if (act !== exp) begin
         errors = errors + 1;
         $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   always @(negedge clk) begin
      if (complete || error) begin
         check("pulse_exclusive", {31'h0, complete & error}, 32'h0);
         if (sb.size() == 0) begin
            checks = checks + 1;
            errors = errors + 1;
            $display("FAIL unexpected_pulse: complete=%0b error=%0b at cycle %0d, none expected",
                     complete, error, cyc);
         end else begin
            mon_e = sb.pop_front();
            check("pulse_kind_error", {31'h0, error}, {31'h0, mon_e.err});
            check("pulse_cycle", cyc, mon_e.cyc);
            check("quotient", {16'h0, quotient}, {16'h0, mon_e.q});
            check("remainder", {16'h0, remainder}, {16'h0, mon_e.r});
         end
      end
   end

   // Caller is at #1 after a rising edge; leaves start high for this one cycle.
   task automatic drive(input logic b, input logic s, input logic [31:0] dd, input logic [15:0] dv);
      start     = 1'b1;
      is_8_bit  = b;
      is_signed = s;
      dividend  = dd;
      divisor   = dv;
   endtask

   task automatic release_start();
      start    = 1'b0;
      dividend = 32'hDEAD_BEEF;
      divisor  = 16'hBEEF;
      is_8_bit = ~is_8_bit;
   endtask

   task automatic issue(input logic b, input logic s, input logic [31:0] dd, input logic [15:0] dv,
                        input logic exp_err, input logic [15:0] eq, input logic [15:0] er,
                        input int lat);
      exp_t e;
      drive(b, s, dd, dv);
      e.err = exp_err;
      e.cyc = cyc + lat;
      if (exp_err) begin
         e.q = prev_q;
         e.r = prev_r;
      end else begin
         e.q    = eq;
         e.r    = er;
         prev_q = eq;
         prev_r = er;
      end
      sb.push_back(e);
      @(posedge clk); #1;
      release_start();
   endtask

   task automatic run(input logic b, input logic s, input logic [31:0] dd, input logic [15:0] dv,
                      input logic exp_err, input logic [15:0] eq, input logic [15:0] er,
                      input int lat);
      issue(b, s, dd, dv, exp_err, eq, er, lat);
      check("busy_after_start", {31'h0, busy}, 32'h1);
      repeat (lat) @(posedge clk);
      #1;
      check("busy_after_done", {31'h0, busy}, 32'h0);
   endtask

   initial begin
      reset_n = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check("reset_quotient", {16'h0, quotient}, 32'h0);
      check("reset_remainder", {16'h0, remainder}, 32'h0);
      check("reset_busy", {31'h0, busy}, 32'h0);
      check("reset_complete", {31'h0, complete}, 32'h0);
      check("reset_error", {31'h0, error}, 32'h0);
      reset_n = 1'b1;
      @(posedge clk); #1;

      // Unsigned word and byte, including don't-care upper operand bits in byte mode.
      run(1'b0, 1'b0, 32'h0001_0000, 16'h0003, 1'b0, 16'h5555, 16'h0001, 18);
      run(1'b1, 1'b0, 32'hABCD_0064, 16'h1207, 1'b0, 16'h000E, 16'h0002, 10);
      // INIT-detected errors keep the previous results.
      run(1'b0, 1'b0, 32'h1234_5678, 16'h0000, 1'b1, 16'h0000, 16'h0000, 2);
      run(1'b0, 1'b0, 32'h0002_0000, 16'h0001, 1'b1, 16'h0000, 16'h0000, 2);
      // Largest quotients that still fit.
      run(1'b0, 1'b0, 32'hFFFE_FFFF, 16'hFFFF, 1'b0, 16'hFFFF, 16'hFFFE, 18);
      run(1'b1, 1'b0, 32'h0000_00FF, 16'h0001, 1'b0, 16'h00FF, 16'h0000, 10);
      run(1'b1, 1'b0, 32'h0000_0100, 16'h0001, 1'b1, 16'h0000, 16'h0000, 2);

`ifdef DIVIDER_SIGNED_EN
      run(1'b0, 1'b1, 32'hFFFF_FFF9, 16'h0002, 1'b0, 16'hFFFD, 16'hFFFF, 18);
      run(1'b1, 1'b1, 32'h0000_0080, 16'h00FF, 1'b1, 16'h0000, 16'h0000, 10);
      run(1'b1, 1'b1, 32'h0000_FF9C, 16'h0007, 1'b0, 16'h00F2, 16'h00FE, 10);
`else
      run(1'b0, 1'b1, 32'hFFFF_FFF9, 16'h0002, 1'b1, 16'h0000, 16'h0000, 2);
      run(1'b1, 1'b1, 32'h0000_0080, 16'h00FF, 1'b0, 16'h0000, 16'h0080, 10);
      run(1'b1, 1'b1, 32'h0000_FF9C, 16'h0007, 1'b1, 16'h0000, 16'h0000, 2);
`endif

      // Start while busy (cycle 5) and in the completing cycle (18) are both ignored.
      issue(1'b0, 1'b0, 32'h0001_0000, 16'h0003, 1'b0, 16'h5555, 16'h0001, 18);
      repeat (4) @(posedge clk);
      #1;
      drive(1'b0, 1'b0, 32'h0000_0000, 16'h0000);
      check("busy_mid_division", {31'h0, busy}, 32'h1);
      @(posedge clk); #1;
      release_start();
      repeat (12) @(posedge clk);
      #1;
      drive(1'b0, 1'b0, 32'h0000_0000, 16'h0000);
      @(posedge clk); #1;
      run(1'b1, 1'b0, 32'h0000_0064, 16'h0007, 1'b0, 16'h000E, 16'h0002, 10);

      // Reset at cycle 7 aborts with no pulse; the first start afterwards is honoured.
      drive(1'b0, 1'b0, 32'hFFFE_FFFF, 16'hFFFF);
      @(posedge clk); #1;
      release_start();
      repeat (6) @(posedge clk);
      #1;
      reset_n = 1'b0;
      #1;
      check("abort_quotient", {16'h0, quotient}, 32'h0);
      check("abort_remainder", {16'h0, remainder}, 32'h0);
      check("abort_busy", {31'h0, busy}, 32'h0);
      check("abort_complete", {31'h0, complete}, 32'h0);
      check("abort_error", {31'h0, error}, 32'h0);
      @(posedge clk); #1;
      reset_n = 1'b1;
      prev_q  = '0;
      prev_r  = '0;
      run(1'b0, 1'b0, 32'h0000_0005, 16'h0000, 1'b1, 16'h0000, 16'h0000, 2);
      run(1'b0, 1'b0, 32'h0000_0007, 16'h0007, 1'b0, 16'h0001, 16'h0000, 18);

      repeat (4) @(posedge clk);
      #1;
      check("scoreboard_drained", sb.size(), 32'h0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
